// File: rtl/user_prng_pkg.sv
// Shared definitions for the xorshift32 PRNG bank: register map, channel
// stride, control register layout and reset/seed helpers.
package user_prng_pkg;

  localparam logic [3:0] OFF_DATA  = 4'h0;
  localparam logic [3:0] OFF_SEED  = 4'h4;
  localparam logic [3:0] OFF_COUNT = 4'h8;
  localparam logic [3:0] OFF_CTRL  = 4'hC;

  localparam int unsigned CH_STRIDE = 16;

  typedef struct packed {
    logic [30:0] rsvd;
    logic        free_run;
  } prng_ctrl_t;

  // A zero state would lock xorshift at zero forever, so it is always coerced to 1.
  function automatic logic [31:0] nonzero(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

  function automatic logic [31:0] reset_seed(input logic [31:0] base, input int unsigned ch);
    return nonzero(base + ch);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/prng_xorshift_step.sv
// One combinational xorshift32 step: y = step(x) with configurable shift amounts.
module prng_xorshift_step #(
  parameter int unsigned SHIFT_A = 13,
  parameter int unsigned SHIFT_B = 17,
  parameter int unsigned SHIFT_C = 5
) (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1  = x_i ^ (x_i << SHIFT_A);
  assign t2  = t1  ^ (t1  >> SHIFT_B);
  assign y_o = t2  ^ (t2  << SHIFT_C);

endmodule

// File: rtl/user_prng_bank.sv
// Multi-channel xorshift32 PRNG peripheral on an OBI subordinate port.
// Each channel has a seedable state, a draw counter and a free-run control bit.
module user_prng_bank
  import user_prng_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [31:0] DEFAULT_SEED   = 32'hDEADBEEF,
  parameter int unsigned SHIFT_A        = 13,
  parameter int unsigned SHIFT_B        = 17,
  parameter int unsigned SHIFT_C        = 5,
  parameter int unsigned ADDR_WIDTH_OBI = 32,
  parameter int unsigned DATA_WIDTH_OBI = 32,
  parameter int unsigned ID_WIDTH_OBI   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [ADDR_WIDTH_OBI-1:0] addr_i,
  input  logic [DATA_WIDTH_OBI-1:0] wdata_i,
  input  logic [ID_WIDTH_OBI-1:0]   aid_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [DATA_WIDTH_OBI-1:0] rdata_o,
  output logic [ID_WIDTH_OBI-1:0]   rid_o,
  output logic                      err_o
);

  localparam int unsigned CH_LSB = $clog2(CH_STRIDE);

  logic [3:0]  ch;
  logic [3:0]  reg_off;
  logic        addr_ok;
  logic        unused_addr;

  logic [31:0] state_all [NUM_CH];
  logic [31:0] count_all [NUM_CH];
  prng_ctrl_t  ctrl_all  [NUM_CH];

  logic [31:0] sel_state;
  logic [31:0] sel_count;
  prng_ctrl_t  sel_ctrl;
  logic [31:0] rdata_d;
  logic        err_d;

  logic                    rvalid_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [ID_WIDTH_OBI-1:0] rid_q;

  assign gnt_o       = req_i;
  assign ch          = addr_i[CH_LSB +: 4];
  assign reg_off     = {addr_i[3:2], 2'b00};
  assign addr_ok     = (addr_i[11:8] == 4'd0) && (32'(ch) < NUM_CH);
  assign unused_addr = ^{addr_i[ADDR_WIDTH_OBI-1:12], addr_i[1:0]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0] state_q;
    logic [31:0] count_q;
    prng_ctrl_t  ctrl_q;
    logic [31:0] step_y;
    logic [31:0] seed_val;
    logic        hit;
    logic        seed_wr;
    logic        data_rd;
    logic        ctrl_wr;

    prng_xorshift_step #(
      .SHIFT_A(SHIFT_A),
      .SHIFT_B(SHIFT_B),
      .SHIFT_C(SHIFT_C)
    ) u_step (
      .x_i(state_q),
      .y_o(step_y)
    );

    assign hit      = req_i && addr_ok && (ch == 4'(c));
    assign seed_wr  = hit &&  we_i && (reg_off == OFF_SEED);
    assign data_rd  = hit && !we_i && (reg_off == OFF_DATA);
    assign ctrl_wr  = hit &&  we_i && (reg_off == OFF_CTRL);
    assign seed_val = nonzero(merge_bytes(state_q, wdata_i[31:0], be_i));

    // Seeding beats a DATA-read advance, which beats free-run; state moves at most once per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= reset_seed(DEFAULT_SEED, c);
        count_q <= 32'd0;
        ctrl_q  <= '0;
      end else begin
        if (seed_wr) begin
          state_q <= seed_val;
          count_q <= 32'd0;
        end else if (data_rd) begin
          state_q <= step_y;
          count_q <= count_q + 32'd1;
        end else if (ctrl_q.free_run) begin
          state_q <= step_y;
        end
        if (ctrl_wr) begin
          ctrl_q <= '{rsvd: '0, free_run: wdata_i[0]};
        end
      end
    end

    assign state_all[c] = state_q;
    assign count_all[c] = count_q;
    assign ctrl_all[c]  = ctrl_q;
  end

  always_comb begin
    sel_state = 32'd0;
    sel_count = 32'd0;
    sel_ctrl  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 4'(c)) begin
        sel_state = state_all[c];
        sel_count = count_all[c];
        sel_ctrl  = ctrl_all[c];
      end
    end
  end

  // Read data comes from the pre-update state; writes and errors return zero.
  always_comb begin
    rdata_d = 32'd0;
    err_d   = 1'b0;
    if (!addr_ok) begin
      err_d = 1'b1;
    end else begin
      case (reg_off)
        OFF_DATA: begin
          if (we_i) err_d   = 1'b1;
          else      rdata_d = sel_state;
        end
        OFF_SEED: begin
          if (!we_i) rdata_d = sel_state;
        end
        OFF_COUNT: begin
          if (we_i) err_d   = 1'b1;
          else      rdata_d = sel_count;
        end
        default: begin
          if (!we_i) rdata_d = 32'(sel_ctrl);
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= req_i;
      if (req_i) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
        rid_q   <= aid_i;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = DATA_WIDTH_OBI'(rdata_q);
  assign err_o    = err_q;
  assign rid_o    = rid_q;

endmodule
